composite_encoder: RTL and testbench

COMPOSITE_ENCODER -- requirements
Module: composite_encoder

---
 rtl/composite_pkg.sv | 50 +++++
 rtl/subcarrier_lut.sv | 44 ++++
 rtl/composite_encoder.sv | 191 +++++++++++++++++++
 tb/tb_composite_encoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/composite_pkg.sv
// composite_pkg: shared precision constants, level/burst defaults
// and the cosine table generator for the composite encoder.
package composite_pkg;

    localparam int COSINE_PRECISION_BITS = 7;
    localparam int YUV_PRECISION_BITS    = 8;
    localparam int COS_W = COSINE_PRECISION_BITS + 1;

    localparam int DEF_SYNC_LEVEL       = 0;
    localparam int DEF_BLANK_LEVEL      = 8;
    localparam int DEF_BLACK_LEVEL_NTSC = 9;
    localparam int DEF_BLACK_LEVEL_PAL  = 8;
    localparam int DEF_BURST_AMP_NTSC   = 64;
    localparam int DEF_BURST_AMP_PAL    = 45;

    // round(127*cos) over the first quarter of a 32-step circle.
    function automatic int cos_quarter(input int n);
        case (n)
            0:       return 127;
            1:       return 125;
            2:       return 117;
            3:       return 106;
            4:       return 90;
            5:       return 71;
            6:       return 49;
            7:       return 25;
            default: return 0;
        endcase
    endfunction

    // Entry k of a 2^phase_bits cosine table, folded from a quarter wave.
    function automatic logic signed [COS_W-1:0] cos_entry(
        input int k,
        input int phase_bits
    );
        int idx;
        int r;
        int m;
        idx = (phase_bits == 4) ? ((k * 2) % 32) : (k % 32);
        r   = idx % 8;
        case (idx / 8)
            0:       m = cos_quarter(r);
            1:       m = -cos_quarter(8 - r);
            2:       m = -cos_quarter(r);
            default: m = cos_quarter(8 - r);
        endcase
        return COS_W'(m);
    endfunction

endpackage

// File: rtl/subcarrier_lut.sv
// subcarrier_lut: registered cos/sin lookup at the subcarrier phase.
// sin is read from the cosine table a quarter turn earlier.
module subcarrier_lut
    import composite_pkg::*;
#(
    parameter int PHASE_BITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [PHASE_BITS-1:0]   i_phase,
    output logic signed [COS_W-1:0] o_cos,
    output logic signed [COS_W-1:0] o_sin
);

    localparam int ENTRIES = 1 << PHASE_BITS;
    localparam logic [PHASE_BITS-1:0] QUARTER =
        PHASE_BITS'(ENTRIES / 4);

    logic signed [COS_W-1:0] w_cos_tab [ENTRIES];
    logic [PHASE_BITS-1:0]   w_sin_idx;
    logic signed [COS_W-1:0] r_cos;
    logic signed [COS_W-1:0] r_sin;

    for (genvar k = 0; k < ENTRIES; k++) begin : g_tab
        assign w_cos_tab[k] = cos_entry(k, PHASE_BITS);
    end

    assign w_sin_idx = i_phase - QUARTER;

    // Latch cos/sin in step with the stage-1 sample registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cos <= '0;
            r_sin <= '0;
        end else begin
            r_cos <= w_cos_tab[i_phase];
            r_sin <= w_cos_tab[w_sin_idx];
        end
    end

    assign o_cos = r_cos;
    assign o_sin = r_sin;

endmodule

// File: rtl/composite_encoder.sv
// composite_encoder: 4-stage NTSC/PAL composite sample pipeline.
// Define COMPOSITE_ENCODER_SATURATE_EN to clip instead of wrap.
module composite_encoder
    import composite_pkg::*;
#(
    parameter int DAC_BITS         = 5,
    parameter int PHASE_BITS       = 4,
    parameter int DAC_LEVEL_SHIFT  = 11,
    parameter int SYNC_LEVEL       = DEF_SYNC_LEVEL,
    parameter int BLANK_LEVEL      = DEF_BLANK_LEVEL,
    parameter int BLACK_LEVEL_NTSC = DEF_BLACK_LEVEL_NTSC,
    parameter int BLACK_LEVEL_PAL  = DEF_BLACK_LEVEL_PAL,
    parameter int BURST_AMP_NTSC   = DEF_BURST_AMP_NTSC,
    parameter int BURST_AMP_PAL    = DEF_BURST_AMP_PAL
) (
    input  logic                  phaseClock,
    input  logic                  resetN,
    input  logic                  palMode,
    input  logic [PHASE_BITS-1:0] subcarrierPhase,
    input  logic                  fieldStart,
    input  logic                  oddField,
    input  logic                  lineStart,
    input  logic                  sync,
    input  logic                  burst,
    input  logic                  blank,
    input  logic signed [8:0]     y,
    input  logic signed [8:0]     u,
    input  logic signed [8:0]     v,
    output logic [DAC_BITS-1:0]   dacSample,
    output logic                  vSwitch
);

    localparam int YW = YUV_PRECISION_BITS + 1;
    localparam int SW = DAC_LEVEL_SHIFT + DAC_BITS + 4;

    localparam logic [DAC_BITS-1:0] L_SYNC  = DAC_BITS'(SYNC_LEVEL);
    localparam logic [DAC_BITS-1:0] L_BLANK = DAC_BITS'(BLANK_LEVEL);
    localparam logic [DAC_BITS-1:0] L_BLK_N = DAC_BITS'(BLACK_LEVEL_NTSC);
    localparam logic [DAC_BITS-1:0] L_BLK_P = DAC_BITS'(BLACK_LEVEL_PAL);

    localparam logic signed [YW-1:0] U_BST_N = YW'(-BURST_AMP_NTSC);
    localparam logic signed [YW-1:0] U_BST_P = YW'(-BURST_AMP_PAL);
    localparam logic signed [YW-1:0] V_BST_P = YW'(BURST_AMP_PAL);

    localparam logic [SW-1:0] L_ROUND = SW'(1) << (DAC_LEVEL_SHIFT - 1);
    localparam logic [SW-1:0] BLANK_TERM =
        (SW'(L_BLANK) << DAC_LEVEL_SHIFT) + L_ROUND;

    logic [DAC_BITS-1:0]     w_level;
    logic signed [YW-1:0]    w_y;
    logic signed [YW-1:0]    w_u;
    logic signed [YW-1:0]    w_v;
    logic signed [COS_W-1:0] w_cos;
    logic signed [COS_W-1:0] w_sin;
    logic signed [SW-1:0]    w_uprod;
    logic signed [SW-1:0]    w_vprod;
    logic [SW-1:0]           w_lvl_term;
    logic [DAC_BITS-1:0]     w_dac;

    logic                    r_vswitch;
    logic [DAC_BITS-1:0]     r_s1_level;
    logic signed [YW-1:0]    r_s1_y;
    logic signed [YW-1:0]    r_s1_u;
    logic signed [YW-1:0]    r_s1_v;
    logic                    r_s1_neg;
    logic signed [SW-1:0]    r_s2_y;
    logic signed [SW-1:0]    r_s2_u;
    logic signed [SW-1:0]    r_s2_v;
    logic signed [SW-1:0]    r_s2_lvl;
    logic signed [SW-1:0]    r_s3_sum;
    logic [DAC_BITS-1:0]     r_dac;

    subcarrier_lut #(
        .PHASE_BITS (PHASE_BITS)
    ) u_lut (
        .i_clk   (phaseClock),
        .i_rst_n (resetN),
        .i_phase (subcarrierPhase),
        .o_cos   (w_cos),
        .o_sin   (w_sin)
    );

    // Track the PAL V-switch; a field start overrides a line toggle.
    always_ff @(posedge phaseClock or negedge resetN) begin
        if (!resetN) begin
            r_vswitch <= 1'b0;
        end else if (!palMode) begin
            r_vswitch <= 1'b0;
        end else if (fieldStart) begin
            r_vswitch <= oddField;
        end else if (lineStart) begin
            r_vswitch <= ~r_vswitch;
        end
    end

    // Pick level and Y/U/V by timing priority sync > burst > blank.
    always_comb begin
        w_level = L_BLANK;
        w_y     = '0;
        w_u     = '0;
        w_v     = '0;
        if (sync) begin
            w_level = L_SYNC;
        end else if (burst) begin
            w_u = palMode ? U_BST_P : U_BST_N;
            w_v = palMode ? V_BST_P : '0;
        end else if (!blank) begin
            w_level = palMode ? L_BLK_P : L_BLK_N;
            w_y     = y;
            w_u     = u;
            w_v     = v;
        end
    end

    // Stage 1: latch the selected sample and its V-switch sign.
    always_ff @(posedge phaseClock or negedge resetN) begin
        if (!resetN) begin
            r_s1_level <= L_BLANK;
            r_s1_y     <= '0;
            r_s1_u     <= '0;
            r_s1_v     <= '0;
            r_s1_neg   <= 1'b0;
        end else begin
            r_s1_level <= w_level;
            r_s1_y     <= w_y;
            r_s1_u     <= w_u;
            r_s1_v     <= w_v;
            r_s1_neg   <= palMode & r_vswitch;
        end
    end

    assign w_uprod    = SW'(r_s1_u) * SW'(w_cos);
    assign w_vprod    = SW'(r_s1_v) * SW'(w_sin);
    assign w_lvl_term = (SW'(r_s1_level) << DAC_LEVEL_SHIFT) + L_ROUND;

    // Stage 2: scale luma, modulate chroma, pre-round the level.
    always_ff @(posedge phaseClock or negedge resetN) begin
        if (!resetN) begin
            r_s2_y   <= '0;
            r_s2_u   <= '0;
            r_s2_v   <= '0;
            r_s2_lvl <= BLANK_TERM;
        end else begin
            r_s2_y   <= SW'(r_s1_y) <<< COSINE_PRECISION_BITS;
            r_s2_u   <= w_uprod;
            r_s2_v   <= r_s1_neg ? -w_vprod : w_vprod;
            r_s2_lvl <= w_lvl_term;
        end
    end

    // Stage 3: sum all terms at a width that cannot overflow.
    always_ff @(posedge phaseClock or negedge resetN) begin
        if (!resetN) begin
            r_s3_sum <= BLANK_TERM;
        end else begin
            r_s3_sum <= r_s2_y + r_s2_u + r_s2_v + r_s2_lvl;
        end
    end

`ifdef COMPOSITE_ENCODER_SATURATE_EN
    localparam logic signed [SW-1:0] DAC_MAX = SW'((1 << DAC_BITS) - 1);
    logic signed [SW-1:0] w_shift;

    assign w_shift = r_s3_sum >>> DAC_LEVEL_SHIFT;

    // Clip the scaled sum into the DAC code range.
    always_comb begin
        w_dac = w_shift[DAC_BITS-1:0];
        if (w_shift[SW-1]) begin
            w_dac = '0;
        end else if (w_shift > DAC_MAX) begin
            w_dac = '1;
        end
    end
`else
    assign w_dac = DAC_BITS'(r_s3_sum >>> DAC_LEVEL_SHIFT);
`endif

    // Stage 4: register the DAC code.
    always_ff @(posedge phaseClock or negedge resetN) begin
        if (!resetN) begin
            r_dac <= L_BLANK;
        end else begin
            r_dac <= w_dac;
        end
    end

    assign dacSample = r_dac;
    assign vSwitch   = r_vswitch;

endmodule

// File: tb/tb_composite_encoder.sv
// tb_composite_encoder: directed vectors against a real-math model
// of the composite encoder, plus hand-computed literal checks.
module tb_composite_encoder;

    localparam int N  = 16;
    localparam real PI = 3.14159265358979;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              pal   = 1'b0;
    logic [3:0]        phase = '0;
    logic              fs    = 1'b0;
    logic              odd   = 1'b0;
    logic              ls    = 1'b0;
    logic              sync  = 1'b0;
    logic              burst = 1'b0;
    logic              blank = 1'b1;
    logic signed [8:0] y     = '0;
    logic signed [8:0] u     = '0;
    logic signed [8:0] v     = '0;
    logic [4:0]        dac;
    logic              vsw;

    int checks = 0;
    int errors = 0;
    int cos_t [N];
    int sin_t [N];
    int q [4];
    bit mvs;
    int a_dac;

    composite_encoder dut (
        .phaseClock      (clk),
        .resetN          (rst_n),
        .palMode         (pal),
        .subcarrierPhase (phase),
        .fieldStart      (fs),
        .oddField        (odd),
        .lineStart       (ls),
        .sync            (sync),
        .burst           (burst),
        .blank           (blank),
        .y               (y),
        .u               (u),
        .v               (v),
        .dacSample       (dac),
        .vSwitch         (vsw)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_dac(
        input bit s, input bit b, input bit bl, input bit p,
        input int ph, input int yy, input int uu, input int vv,
        input bit vs
    );
        int lvl;
        int ys;
        int us;
        int vsg;
        int sum;
        int sh;
        lvl = 8; ys = 0; us = 0; vsg = 0;
        if (s) begin
            lvl = 0;
        end else if (b) begin
            us  = p ? -45 : -64;
            vsg = p ? 45 : 0;
        end else if (!bl) begin
            lvl = p ? 8 : 9;
            ys = yy; us = uu; vsg = vv;
        end
        if (p && vs) vsg = -vsg;
        sum = lvl * 2048 + 1024 + ys * 128
            + us * cos_t[ph] + vsg * sin_t[ph];
        sh = sum >>> 11;
`ifdef COMPOSITE_ENCODER_SATURATE_EN
        if (sh < 0) sh = 0;
        if (sh > 31) sh = 31;
        return sh;
`else
        return sh & 31;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic put(
        input bit s, input bit b, input bit bl, input bit p,
        input int ph, input int yy, input int uu, input int vv
    );
        sync  = s;
        burst = b;
        blank = bl;
        pal   = p;
        phase = 4'(ph);
        y     = 9'(yy);
        u     = 9'(uu);
        v     = 9'(vv);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: 4-deep expectation pipe and V-switch state.
    initial begin
        for (int i = 0; i < 4; i++) q[i] = 8;
        mvs = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) q[i] = 8;
                mvs = 1'b0;
            end else begin
                q[3] = q[2];
                q[2] = q[1];
                q[1] = q[0];
                q[0] = model_dac(sync, burst, blank, pal,
                                 int'(phase), int'(y), int'(u),
                                 int'(v), mvs);
                if (!pal) mvs = 1'b0;
                else if (fs) mvs = odd;
                else if (ls) mvs = ~mvs;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (int'(dac) != q[3]) begin
                errors++;
                $display("FAIL stream dacSample t=%0t: got %0d, expected %0d",
                         $time, dac, q[3]);
            end
            checks++;
            if (vsw != mvs) begin
                errors++;
                $display("FAIL stream vSwitch t=%0t: got %0d, expected %0d",
                         $time, vsw, mvs);
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++)
            cos_t[k] = rnd(127.0 * $cos(2.0 * PI * real'(k) / real'(N)));
        for (int k = 0; k < N; k++)
            sin_t[k] = cos_t[(k - N / 4 + N) % N];

        chk("model cos0", cos_t[0], 127);
        chk("model cos2", cos_t[2], 90);
        chk("model sin4", sin_t[4], 127);
        chk("model sin0", sin_t[0], 0);

        #1 rst_n = 1'b0;
        hold(3);
        chk("reset dac", int'(dac), 8);
        chk("reset vsw", int'(vsw), 0);
        rst_n = 1'b1;

        put(0, 0, 0, 0, 0, 255, 0, 0);
        hold(5);
        chk("white ntsc", int'(dac), 25);
        put(0, 0, 0, 1, 0, 255, 0, 0);
        hold(5);
        chk("white pal", int'(dac), 24);
        put(1, 1, 1, 1, 0, 255, 100, 100);
        hold(5);
        chk("sync", int'(dac), 0);
        put(0, 0, 1, 0, 3, 255, 100, 100);
        hold(5);
        chk("blank", int'(dac), 8);

        put(0, 1, 1, 0, 0, 200, 50, 50);
        hold(5);
        chk("burst ntsc ph0", int'(dac), 4);
        put(0, 1, 0, 1, 0, 200, 50, 50);
        hold(5);
        chk("burst pal ph0", int'(dac), 5);

        put(0, 1, 0, 1, 4, 0, 0, 0);
        fs = 1'b1; odd = 1'b0;
        hold(1);
        fs = 1'b0;
        hold(5);
        a_dac = int'(dac);
        chk("burst pal ph4 vs0", a_dac, 11);
        fs = 1'b1; odd = 1'b1;
        hold(1);
        fs = 1'b0;
        hold(5);
        chk("burst pal ph4 vs1", int'(dac), 5);
        chk("burst ph4 differs", int'(a_dac != int'(dac)), 1);

        put(0, 0, 1, 1, 0, 0, 0, 0);
        fs = 1'b1; odd = 1'b1;
        hold(1);
        chk("vsw field load", int'(vsw), 1);
        fs = 1'b0; ls = 1'b1;
        hold(1);
        chk("vsw line 1", int'(vsw), 0);
        hold(1);
        chk("vsw line 2", int'(vsw), 1);
        hold(1);
        chk("vsw line 3", int'(vsw), 0);
        fs = 1'b1; odd = 1'b0;
        hold(1);
        chk("vsw coincide odd0", int'(vsw), 0);
        fs = 1'b0;
        hold(1);
        chk("vsw toggle", int'(vsw), 1);
        fs = 1'b1; odd = 1'b1;
        hold(1);
        chk("vsw coincide odd1", int'(vsw), 1);
        fs = 1'b0; ls = 1'b0;
        pal = 1'b0; fs = 1'b1;
        hold(1);
        chk("vsw ntsc held", int'(vsw), 0);
        fs = 1'b0;

        put(0, 0, 0, 1, 0, 255, 255, 0);
        hold(5);
`ifdef COMPOSITE_ENCODER_SATURATE_EN
        chk("sat high", int'(dac), 31);
`else
        chk("wrap high", int'(dac), 8);
`endif
        put(0, 0, 0, 1, 0, 0, -255, 0);
        hold(5);
`ifdef COMPOSITE_ENCODER_SATURATE_EN
        chk("sat low", int'(dac), 0);
`else
        chk("wrap low", int'(dac), 24);
`endif

        for (int i = 0; i < 64; i++) begin
            put(i % 11 == 0, (i % 9 == 3) || (i % 9 == 4),
                i % 6 == 5, (i / 7) % 2 == 1, i % 16,
                (i * 37) % 256, ((i * 53) % 511) - 255,
                ((i * 29) % 511) - 255);
            fs  = (i % 17 == 8);
            odd = (i % 2 == 1);
            ls  = (i % 5 == 2) || (i % 13 == 8);
            hold(1);
        end
        fs = 1'b0; ls = 1'b0;

        put(0, 0, 0, 1, 0, 255, 0, 0);
        fs = 1'b1; odd = 1'b1;
        hold(1);
        fs = 1'b0;
        hold(5);
        chk("pre-reset dac", int'(dac), 24);
        chk("pre-reset vsw", int'(vsw), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset dac", int'(dac), 8);
        chk("async reset vsw", int'(vsw), 0);
        hold(1);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            hold(1);
            chk("post-reset blank", int'(dac), 8);
        end
        hold(1);
        chk("post-reset first", int'(dac), 24);
        hold(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
